// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: architectural register file geometry,
// register-index type and the hard-wired zero register.
package mips_pkg;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int CW       = 2;
  localparam int REG_ZERO = 0;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/wb_scoreboard_if.sv
// Bundle between the MEM/decode stages (master) and the writeback scoreboard (slave).
// Handshake: id_issue is a valid and ~id_hazard its ready; an issue transfers only when both hold.
interface wb_scoreboard_if #(
  parameter int AW = mips_pkg::AW,
  parameter int DW = mips_pkg::DW
);
  logic          mem_valid;
  logic          mem_regwrite;
  logic          mem_memtoreg;
  logic [AW-1:0] mem_dest;
  logic [DW-1:0] mem_alu;
  logic [DW-1:0] mem_rdata;
  logic          id_issue;
  logic [AW-1:0] id_dest;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          regwrite;
  logic [AW-1:0] writebackreg;
  logic [DW-1:0] data_towrite_memwb;
  logic [DW-1:0] id_rd1;
  logic [DW-1:0] id_rd2;
  logic          id_hazard;

  modport master (
    output mem_valid, mem_regwrite, mem_memtoreg, mem_dest, mem_alu, mem_rdata,
    output id_issue, id_dest, id_rs, id_rt, id_rs_used, id_rt_used, rf_rd1, rf_rd2,
    input  regwrite, writebackreg, data_towrite_memwb, id_rd1, id_rd2, id_hazard
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_memtoreg, mem_dest, mem_alu, mem_rdata,
    input  id_issue, id_dest, id_rs, id_rt, id_rs_used, id_rt_used, rf_rd1, rf_rd2,
    output regwrite, writebackreg, data_towrite_memwb, id_rd1, id_rd2, id_hazard
  );
endinterface

// File: rtl/sb_counter_bank.sv
// Per-register pending-writer counters with one increment, one decrement
// and three read ports (two sources plus the issuing destination).
module sb_counter_bank
  import mips_pkg::*;
#(
  parameter int NREG = mips_pkg::NREG,
  parameter int AW   = mips_pkg::AW,
  parameter int CW   = mips_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_en,
  input  logic [AW-1:0] inc_idx,
  input  logic          dec_en,
  input  logic [AW-1:0] dec_idx,
  input  logic [AW-1:0] rd_idx_a,
  input  logic [AW-1:0] rd_idx_b,
  input  logic [AW-1:0] rd_idx_c,
  output logic [CW-1:0] rd_cnt_a,
  output logic [CW-1:0] rd_cnt_b,
  output logic [CW-1:0] rd_cnt_c
);
  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  // Register zero is masked out here, so its counter never leaves reset.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[inc_idx] = 1'b1;
    if (dec_en) dec_vec[dec_idx] = 1'b1;
    inc_vec[REG_ZERO] = 1'b0;
    dec_vec[REG_ZERO] = 1'b0;
  end

  // A commit with no recorded producer (e.g. writes issued before the
  // scoreboard was tracking them) must not wrap the counter to full.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r] && cnt[r] != '1)
          cnt[r] <= cnt[r] + CW'(1);
        else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  assign rd_cnt_a = cnt[rd_idx_a];
  assign rd_cnt_b = cnt[rd_idx_b];
  assign rd_cnt_c = cnt[rd_idx_c];
endmodule

// File: rtl/wb_scoreboard.sv
// Writeback stage: MEM/WB register driving the register file write port,
// same-cycle bypass onto decode operands, and the RAW/saturation stall.
module wb_scoreboard #(
  parameter int NREG = mips_pkg::NREG,
  parameter int AW   = mips_pkg::AW,
  parameter int DW   = mips_pkg::DW,
  parameter int CW   = mips_pkg::CW
) (
  input logic            clk,
  input logic            rst,
  wb_scoreboard_if.slave bus
);
  import mips_pkg::*;

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic          regwrite_q;
  logic [AW-1:0] wbreg_q;
  logic [DW-1:0] wdata_q;

  // Index and data hold across idle edges; only the enable drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wbreg_q    <= '0;
      wdata_q    <= '0;
    end else if (bus.mem_valid) begin
      regwrite_q <= bus.mem_regwrite && (bus.mem_dest != ZERO_IDX);
      wbreg_q    <= bus.mem_dest;
      wdata_q    <= bus.mem_memtoreg ? bus.mem_rdata : bus.mem_alu;
    end else begin
      regwrite_q <= 1'b0;
    end
  end

  assign bus.regwrite           = regwrite_q;
  assign bus.writebackreg       = wbreg_q;
  assign bus.data_towrite_memwb = wdata_q;

  logic [CW-1:0] cnt_rs, cnt_rt, cnt_dest;
  logic          inc_en;
  logic          hit_rs, hit_rt;
  logic          busy_rs, busy_rt, sat_dest;
  logic          hazard;

  sb_counter_bank #(.NREG(NREG), .AW(AW), .CW(CW)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .inc_en   (inc_en),
    .inc_idx  (bus.id_dest),
    .dec_en   (regwrite_q),
    .dec_idx  (wbreg_q),
    .rd_idx_a (bus.id_rs),
    .rd_idx_b (bus.id_rt),
    .rd_idx_c (bus.id_dest),
    .rd_cnt_a (cnt_rs),
    .rd_cnt_b (cnt_rt),
    .rd_cnt_c (cnt_dest)
  );

  assign hit_rs = regwrite_q && (wbreg_q == bus.id_rs) && (bus.id_rs != ZERO_IDX);
  assign hit_rt = regwrite_q && (wbreg_q == bus.id_rt) && (bus.id_rt != ZERO_IDX);

  assign bus.id_rd1 = hit_rs ? wdata_q : bus.rf_rd1;
  assign bus.id_rd2 = hit_rt ? wdata_q : bus.rf_rd2;

  // The committing writer is visible through the bypass, so it no longer counts.
  assign busy_rs  = cnt_rs > (hit_rs ? CW'(1) : CW'(0));
  assign busy_rt  = cnt_rt > (hit_rt ? CW'(1) : CW'(0));
  assign sat_dest = (cnt_dest == '1);

  assign hazard = (bus.id_rs_used && busy_rs) ||
                  (bus.id_rt_used && busy_rt) ||
                  (bus.id_issue && sat_dest);

  assign bus.id_hazard = hazard;
  assign inc_en        = bus.id_issue && !hazard && (bus.id_dest != ZERO_IDX);
endmodule
